// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480 @ 60 Hz raster constants (100 MHz system clock, 25 MHz pixel
// rate) and the 12-bit {R,G,B} colour palette used by the drawing controllers.
// No ports.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    // Raster timing, all counts in pixels / lines
    localparam int unsigned CLK_DIV         = 32'd4;
    localparam int unsigned H_TOTAL         = 32'd800;
    localparam int unsigned H_SYNC          = 32'd96;
    localparam int unsigned H_VIS_START     = 32'd144;
    localparam int unsigned H_VIS_END       = 32'd783;
    localparam int unsigned V_TOTAL         = 32'd525;
    localparam int unsigned V_SYNC          = 32'd2;
    localparam int unsigned V_VIS_START     = 32'd35;
    localparam int unsigned V_VIS_END       = 32'd514;
    localparam int unsigned FRAMES_PER_TICK = 32'd1;

    // 12-bit colours, {R,G,B} nibbles
    localparam logic [11:0] BLACK   = 12'h000;
    localparam logic [11:0] RED     = 12'hF00;
    localparam logic [11:0] GREEN   = 12'h0F0;
    localparam logic [11:0] YELLOW  = 12'hFF0;
    localparam logic [11:0] CYAN    = 12'h0FF;
    localparam logic [11:0] MAGENTA = 12'hF0F;
    localparam logic [11:0] ORANGE  = 12'hF80;
    localparam logic [11:0] PURPLE  = 12'h80F;
    localparam logic [11:0] BLUE    = 12'h00F;

endpackage

// File: rtl/vga_pix_div.sv
// -----------------------------------------------------------------------------
// vga_pix_div
// Divides the system clock down to a one-clock pixel enable.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   pix_pre  out  combinational, high the clock before pix_en
//   pix_en   out  registered, high for 1 clk in every CLK_DIV clks; the first
//                 pulse appears CLK_DIV clks after reset release
// -----------------------------------------------------------------------------
module vga_pix_div #(
    parameter int unsigned CLK_DIV = vga_timing_pkg::CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic pix_pre,
    output logic pix_en
);
    import vga_timing_pkg::*;

    localparam int unsigned      DIV_W    = (CLK_DIV > 32'd1) ? $clog2(CLK_DIV) : 32'd1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 32'd1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'd1);

    logic [DIV_W-1:0] div_r;
    logic             pix_en_r;

    // The enable is the registered terminal count of the divider
    assign pix_pre = (div_r == DIV_LAST);
    assign pix_en  = pix_en_r;

    // Divider counter and registered pixel enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r    <= '0;
            pix_en_r <= 1'b0;
        end else begin
            if (pix_pre) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + DIV_ONE;
            end
            pix_en_r <= pix_pre;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// 640x480 @ 60 Hz raster timing generator with colour pin mux and frame /
// game-tick strobes.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   pix_en            one-clk pixel-rate enable
//   hCount, vCount    pixel / line counters
//   bright            high inside the visible window
//   hSync, vSync      active-low syncs
//   frame_start       one-clk pulse with the pix_en that wraps to (0,0)
//   game_tick         one-clk pulse every FRAMES_PER_TICK frames
//   rgb_in            {R,G,B} colour from the drawing controller
//   vga_r/g/b         colour pins, black outside the visible window
// Build option VGA_OUT_REG_EN: when defined, hSync/vSync/bright/vga_r/g/b are
// registered on pix_en and lag the counters by one pixel.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned CLK_DIV         = vga_timing_pkg::CLK_DIV,
    parameter int unsigned H_TOTAL         = vga_timing_pkg::H_TOTAL,
    parameter int unsigned H_SYNC          = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_VIS_START     = vga_timing_pkg::H_VIS_START,
    parameter int unsigned H_VIS_END       = vga_timing_pkg::H_VIS_END,
    parameter int unsigned V_TOTAL         = vga_timing_pkg::V_TOTAL,
    parameter int unsigned V_SYNC          = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_VIS_START     = vga_timing_pkg::V_VIS_START,
    parameter int unsigned V_VIS_END       = vga_timing_pkg::V_VIS_END,
    parameter int unsigned FRAMES_PER_TICK = vga_timing_pkg::FRAMES_PER_TICK
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pix_en,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        bright,
    output logic        hSync,
    output logic        vSync,
    output logic        frame_start,
    output logic        game_tick,
    input  logic [11:0] rgb_in,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);
    import vga_timing_pkg::*;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 32'd1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 32'd1);
    localparam logic [9:0] H_SYNCW = 10'(H_SYNC);
    localparam logic [9:0] V_SYNCW = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_S = 10'(H_VIS_START);
    localparam logic [9:0] H_VIS_E = 10'(H_VIS_END);
    localparam logic [9:0] V_VIS_S = 10'(V_VIS_START);
    localparam logic [9:0] V_VIS_E = 10'(V_VIS_END);
    localparam logic [7:0] F_LAST  = 8'(FRAMES_PER_TICK - 32'd1);

    logic        pix_pre_s;
    logic        pix_en_s;
    logic [9:0]  h_r, v_r;
    logic [9:0]  h_nxt_s, v_nxt_s;
    logic        fs_nxt_s;
    logic        frame_start_r, game_tick_r;
    logic [7:0]  frame_cnt_r;
    logic        hsync_s, vsync_s, bright_s;
    logic [11:0] colour_s;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk     (clk),
        .rst     (rst),
        .pix_pre (pix_pre_s),
        .pix_en  (pix_en_s)
    );

    assign pix_en      = pix_en_s;
    assign hCount      = h_r;
    assign vCount      = v_r;
    assign frame_start = frame_start_r;
    assign game_tick   = game_tick_r;

    // Next counter values, advancing only on the pixel enable
    always_comb begin
        h_nxt_s = h_r;
        v_nxt_s = v_r;
        if (pix_en_s) begin
            if (h_r == H_LAST) begin
                h_nxt_s = 10'd0;
                if (v_r == V_LAST) begin
                    v_nxt_s = 10'd0;
                end else begin
                    v_nxt_s = v_r + 10'd1;
                end
            end else begin
                h_nxt_s = h_r + 10'd1;
            end
        end else begin
            h_nxt_s = h_r;
            v_nxt_s = v_r;
        end
    end

    // The strobe is registered one clock ahead so it lands on the very clk
    // whose pix_en moves the counters from the last pixel back to (0,0).
    // Looking at the next counter values keeps this right even for CLK_DIV=1.
    assign fs_nxt_s = pix_pre_s && (h_nxt_s == H_LAST) && (v_nxt_s == V_LAST);

    // Raster counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_r <= 10'd0;
            v_r <= 10'd0;
        end else begin
            h_r <= h_nxt_s;
            v_r <= v_nxt_s;
        end
    end

    // Frame strobe, frame counter and game tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start_r <= 1'b0;
            game_tick_r   <= 1'b0;
            frame_cnt_r   <= 8'd0;
        end else begin
            frame_start_r <= fs_nxt_s;
            game_tick_r   <= fs_nxt_s && (frame_cnt_r == F_LAST);
            if (frame_start_r) begin
                if (frame_cnt_r == F_LAST) begin
                    frame_cnt_r <= 8'd0;
                end else begin
                    frame_cnt_r <= frame_cnt_r + 8'd1;
                end
            end
        end
    end

    // Sync / visible-window decode and colour blanking from the counters
    always_comb begin
        hsync_s  = ~(h_r < H_SYNCW);
        vsync_s  = ~(v_r < V_SYNCW);
        bright_s = (h_r >= H_VIS_S) && (h_r <= H_VIS_E) &&
                   (v_r >= V_VIS_S) && (v_r <= V_VIS_E);
        if (bright_s) begin
            colour_s = rgb_in;
        end else begin
            colour_s = BLACK;
        end
    end

`ifdef VGA_OUT_REG_EN
    logic        hsync_r, vsync_r, bright_r;
    logic [11:0] colour_r;

    // Pixel-aligned output stage: captures the decode of the pixel being left
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_r  <= 1'b0;
            vsync_r  <= 1'b0;
            bright_r <= 1'b0;
            colour_r <= BLACK;
        end else if (pix_en_s) begin
            hsync_r  <= hsync_s;
            vsync_r  <= vsync_s;
            bright_r <= bright_s;
            colour_r <= colour_s;
        end
    end

    assign hSync  = hsync_r;
    assign vSync  = vsync_r;
    assign bright = bright_r;
    assign vga_r  = colour_r[11:8];
    assign vga_g  = colour_r[7:4];
    assign vga_b  = colour_r[3:0];
`else
    assign hSync  = hsync_s;
    assign vSync  = vsync_s;
    assign bright = bright_s;
    assign vga_r  = colour_s[11:8];
    assign vga_g  = colour_s[7:4];
    assign vga_b  = colour_s[3:0];
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Scoreboard bench for vga_timing_gen on a scaled-down raster (20x10 pixels,
// CLK_DIV=4, FRAMES_PER_TICK=3) so that many frames fit in a short run.
// Expected per-clock outputs come from a closed-form model of clocks since
// reset release; VGA_OUT_REG_EN selects the one-pixel-lagged expectation.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int CD  = 4;
    localparam int HT  = 20;
    localparam int HS  = 3;
    localparam int HVS = 5;
    localparam int HVE = 16;
    localparam int VT  = 10;
    localparam int VS  = 2;
    localparam int VVS = 3;
    localparam int VVE = 7;
    localparam int FPT = 3;
    localparam int FR  = HT * VT;
    localparam int FRAME_CLKS = CD * FR;

    logic        clk;
    logic        rst;
    logic        pix_en;
    logic [9:0]  hCount, vCount;
    logic        bright, hSync, vSync, frame_start, game_tick;
    logic [11:0] rgb_in;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [37:0] dut_vec;

    typedef struct {
        int          tcyc;
        string       tag;
        logic [37:0] vec;
    } exp_t;

    exp_t q[$];
    int   t_cyc;
    int   vectors;
    int   miscompares;
    int   fs_cnt;
    int   gt_cnt;

    vga_timing_gen #(
        .CLK_DIV         (CD),
        .H_TOTAL         (HT),
        .H_SYNC          (HS),
        .H_VIS_START     (HVS),
        .H_VIS_END       (HVE),
        .V_TOTAL         (VT),
        .V_SYNC          (VS),
        .V_VIS_START     (VVS),
        .V_VIS_END       (VVE),
        .FRAMES_PER_TICK (FPT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hCount      (hCount),
        .vCount      (vCount),
        .bright      (bright),
        .hSync       (hSync),
        .vSync       (vSync),
        .frame_start (frame_start),
        .game_tick   (game_tick),
        .rgb_in      (rgb_in),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    assign dut_vec = {pix_en, hCount, vCount, bright, hSync, vSync,
                      frame_start, game_tick, vga_r, vga_g, vga_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clocks elapsed since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) t_cyc <= 0;
        else     t_cyc <= t_cyc + 1;
    end

    // Expected output vector for clock t after release
    function automatic logic [37:0] model(input int t, input logic [11:0] rgb);
        int n, m, h, v, mh, mv, k;
        logic pe, fs, gt, hs, vs, br;
        logic [11:0] col;
        pe = (t > 0) && ((t % CD) == 0);
        n  = (t == 0) ? 0 : (t - 1) / CD;
        h  = n % HT;
        v  = (n / HT) % VT;
        fs = pe && (((t / CD) % FR) == 0);
        k  = t / FRAME_CLKS;
        gt = fs && ((k % FPT) == 0);
`ifdef VGA_OUT_REG_EN
        m  = (n > 0) ? n - 1 : 0;
`else
        m  = n;
`endif
        mh  = m % HT;
        mv  = (m / HT) % VT;
        hs  = !(mh < HS);
        vs  = !(mv < VS);
        br  = (mh >= HVS) && (mh <= HVE) && (mv >= VVS) && (mv <= VVE);
        col = br ? rgb : 12'h000;
        return {pe, 10'(h), 10'(v), br, hs, vs, fs, gt, col};
    endfunction

    task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t_cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Queue expectations for clocks from..to; rgb_old covers clocks before the
    // new colour can have reached a registered output stage
    task automatic push_range(input string tag, input int from, input int to,
                              input logic [11:0] rgb_new, input logic [11:0] rgb_old);
        int   t1;
        exp_t e;
`ifdef VGA_OUT_REG_EN
        int p;
        p = t_cyc;
        while (!((p > 0) && ((p % CD) == 0))) p++;
        t1 = p + 1;
`else
        t1 = from;
`endif
        for (int s = from; s <= to; s++) begin
            e.tcyc = s;
            e.tag  = tag;
            e.vec  = model(s, (s < t1) ? rgb_old : rgb_new);
            q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = budget;
        while ((q.size() > 0) && (b > 0)) begin
            @(negedge clk);
            b--;
        end
        check_int("drain_left", q.size(), 0);
        q.delete();
    endtask

    // Monitor: pops expectations due this clock and counts strobes
    initial begin
        exp_t e;
        fs_cnt = 0;
        gt_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fs_cnt = 0;
                gt_cnt = 0;
            end else begin
                if (frame_start) fs_cnt++;
                if (game_tick)   gt_cnt++;
            end
            while ((q.size() > 0) && (q[0].tcyc <= t_cyc)) begin
                e = q.pop_front();
                if (e.tcyc < t_cyc) check_int({e.tag, "_late"}, t_cyc, e.tcyc);
                else                check(e.tag, dut_vec, e.vec);
            end
        end
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        rgb_in = 12'h000;
        repeat (3) @(negedge clk);

        // Reset state
        push_range("reset", 0, 0, 12'h000, 12'h000);
        wait_drain(4);

        // Release and run two full frames with magenta
        rst    = 1'b0;
        rgb_in = vga_timing_pkg::MAGENTA;
        push_range("frames_a", 1, 2 * FRAME_CLKS, 12'hF0F, 12'h000);
        wait_drain(2 * FRAME_CLKS + 20);

        // Continue to the end of frame 7 with a different colour
        rgb_in = 12'h5A3;
        push_range("frames_b", t_cyc + 1, 7 * FRAME_CLKS, 12'h5A3, 12'hF0F);
        wait_drain(5 * FRAME_CLKS + 20);
        #1;
        check_int("frame_start_count", fs_cnt, 7);
        check_int("game_tick_count", gt_cnt, 2);

        // Run to pixel (10,5) of frame 8, then reset mid-line
        push_range("to_mid", t_cyc + 1, CD * (7 * FR + 5 * HT + 10) + 2, 12'h5A3, 12'h5A3);
        wait_drain(FRAME_CLKS);
        #1 rst = 1'b1;
        #1 check("rst_async", dut_vec, model(0, 12'h5A3));
        push_range("rst_hold", 0, 0, 12'h5A3, 12'h5A3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Restart: next frame_start exactly one frame after release, no tick
        push_range("restart", 1, FRAME_CLKS + 10, 12'h5A3, 12'h5A3);
        wait_drain(FRAME_CLKS + 30);
        #1;
        check_int("restart_fs_count", fs_cnt, 1);
        check_int("restart_gt_count", gt_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Produces the raster timing that all pixel-drawing controllers consume: hCount, vCount, bright, active-low hSync/vSync for a 640x480 display at 60 Hz, driven from a 100 MHz system clock. It also muxes the drawing controller's 12-bit rgb onto the 4/4/4 VGA pins and issues one-clock frame and game-tick strobes. Game controllers use these strobes to advance positions once per N frames. Sits between the board top level and the drawing controllers, and is the counterpart that drives their hCount/vCount/bright inputs.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate)
H_TOTAL, 800, pixels per line including blanking
H_SYNC, 96, hSync low width in pixels (hCount 0..95)
H_VIS_START, 144, first visible hCount
H_VIS_END, 783, last visible hCount
V_TOTAL, 525, lines per frame
V_SYNC, 2, vSync low width in lines (vCount 0..1)
V_VIS_START, 35, first visible vCount
V_VIS_END, 514, last visible vCount
FRAMES_PER_TICK, 1, frames between game_tick pulses (valid range 1..255)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  reset, asynchronous, active-high
pix_en  out  1  one-clk pixel-rate enable
hCount  out  10  horizontal pixel counter
vCount  out  10  vertical line counter
bright  out  1  high inside the visible window
hSync  out  1  horizontal sync, active low
vSync  out  1  vertical sync, active low
frame_start  out  1  one-clk pulse at the last pixel of each frame
game_tick  out  1  one-clk pulse every FRAMES_PER_TICK frames
rgb_in  in  12  pixel colour from the drawing controller, {R,G,B} nibbles
vga_r  out  4  red pin
vga_g  out  4  green pin
vga_b  out  4  blue pin

Behaviour:
- Reset: div=0, hCount=0, vCount=0, frame counter=0, pix_en=0, frame_start=0, game_tick=0. hSync and vSync are 0 during reset, because count 0 lies inside the sync pulse. bright=0 and vga_r/g/b=0 during reset.
- div counts 0..CLK_DIV-1 and wraps to 0. pix_en is registered and high for exactly 1 clk in every CLK_DIV clks. The first pix_en after reset release occurs CLK_DIV clks after release.
- On pix_en, hCount advances by 1. When hCount reaches H_TOTAL-1, it wraps to 0 and vCount advances by 1. When vCount reaches V_TOTAL-1 as hCount wraps, vCount also wraps to 0. Counters never exceed their TOTAL-1.
- Sync and window decode (combinational from the counters):
  - hSync = ~(hCount < H_SYNC)
  - vSync = ~(vCount < V_SYNC)
  - bright = H_VIS_START <= hCount <= H_VIS_END and V_VIS_START <= vCount <= V_VIS_END
- frame_start: registered; asserted on the same clk as the pix_en that moves the counters from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- Frame counter: 8 bits. It increments on each frame_start event and wraps to 0 at FRAMES_PER_TICK-1. game_tick pulses for 1 clk, coincident with the frame_start whose event brings the counter to that wrap. With FRAMES_PER_TICK=1, game_tick equals frame_start.
- Pixel output: vga_{r,g,b} = bright ? rgb_in nibbles [11:8],[7:4],[3:0] : 0. Output is forced black outside the window regardless of rgb_in.
- Reset mid-line: all counters return to 0 asynchronously. Timing restarts at (0,0) with no partial-frame strobe.

Optional Feature:
VGA_OUT_REG_EN:
- Defined: hSync, vSync, bright and vga_r/g/b are registered on pix_en, so they lag hCount/vCount by exactly one pixel (CLK_DIV clks). This suits drawing controllers that register their rgb. All registered outputs reset to hSync=0, vSync=0, bright=0, colour 0.
- Undefined: these outputs are combinational from the counters with zero latency, as stated in Behaviour.

Decomposition:
- Package vga_timing_pkg holds the default timing constants (H_*/V_* values above, CLK_DIV) and the 12-bit colour constants BLACK, RED, GREEN, YELLOW, CYAN, MAGENTA, ORANGE, PURPLE and BLUE, for reuse by every drawing controller.
- One sub-module, vga_pix_div: the CLK_DIV counter producing pix_en, reused by any block needing the pixel enable.

Test Plan:
- Reset release, count clks to each pix_en -> pix_en high 1 clk at clk 4, 8, 12, ...; hCount=1 after the first pix_en.
- Run one full line -> hSync low for exactly 96 pix_en (384 clks); hCount wraps 799->0 and vCount 0->1 on the same pix_en.
- Run one full frame -> frame_start seen once per 1,680,000 clks at (799,524)->(0,0). vSync is low for exactly 2 lines (6400 clks).
- Sample bright and the colour pins with rgb_in=12'hF0F:
  - at (143,35) and (784,35): bright=0, pins 0/0/0
  - at (144,35), (783,514): bright=1, pins F/0/F
  - at (300,515): bright=0
- FRAMES_PER_TICK=3, run 7 frames -> game_tick on frame_start 3 and 6 only, each 1 clk wide.
- Assert rst at (400,200) for 2 clks -> counters 0 immediately; next frame_start exactly 1,680,000 clks after release. With VGA_OUT_REG_EN defined, bright rises one pixel after hCount=144.
